// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/stall controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   It produces the stage-register enables, the IF/ID flush and the ID/EX bubble,
//   and the EX-stage forwarding selects. A 4-state FSM sequences the multi-cycle
//   events: load-use stall, taken-branch flush and data-memory wait.
//
//   Optional feature macro: PERF_CNT_EN (enables the stall/flush/memwait counters)
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-low reset
//   id_*                  source registers and use flags of the instruction in ID
//   ex_*                  sources, destination, load flag and branch outcome in EX
//   mem_*/wb_*            destination register and write flag in MEM / WB
//   dmem_req/dmem_ready   data-memory handshake of the MEM stage
//   pc_en..exmem_en       stage register load enables
//   ifid_flush            clears IF/ID to a NOP
//   idex_bubble           loads a NOP into ID/EX
//   fwd_a/fwd_b           EX operand select: 00 regfile, 10 MEM, 01 WB
//   state                 0 RUN, 1 LOAD_STALL, 2 BR_FLUSH, 3 MEM_WAIT
//   mem_err               sticky data-memory timeout flag
//   stall_cnt/flush_cnt/memwait_cnt  saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  memwait_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int FW = $clog2(FLUSH_DEPTH + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_DEPTH - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;      // state to resume after MEM_WAIT
  logic [FW-1:0]   fcnt_q, fcnt_d;    // remaining BR_FLUSH cycles
  logic [TW-1:0]   tmo_q, tmo_d;      // MEM_WAIT cycle number (1-based)
  logic            err_q, err_d;

  logic mem_wait, load_use;

  // Forwarding: MEM beats WB, r0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (mem_regwrite && mem_waddr != '0 && mem_waddr == src)   return 2'b10;
    else if (wb_regwrite && wb_waddr != '0 && wb_waddr == src) return 2'b01;
    else                                                        return 2'b00;
  endfunction

  always_comb begin
    mem_wait = dmem_req && !dmem_ready;
    load_use = ex_memread && ex_waddr != '0 &&
               ((id_uses_rs && id_rs == ex_waddr) || (id_uses_rt && id_rt == ex_waddr));
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    fcnt_d      = fcnt_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = fwd_sel(ex_rs);
    fwd_b       = fwd_sel(ex_rt);

    unique case (state_q)
      RUN, LOAD_STALL: begin
        if (mem_wait) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          state_d = MEM_WAIT;
          ret_d   = RUN;
          tmo_d   = TW'(1);
        end else if (state_q == RUN && ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = BR_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == RUN && load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LOAD_STALL;
        end else begin
          // LOAD_STALL lasts one cycle; load-use is not re-checked there.
          state_d = RUN;
        end
      end
      BR_FLUSH: begin
        if (mem_wait) begin
          // Freeze; the remaining flush count is kept for the resume.
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          state_d = MEM_WAIT;
          ret_d   = BR_FLUSH;
          tmo_d   = TW'(1);
        end else begin
          ifid_flush = 1'b1;
          fcnt_d     = fcnt_q - FW'(1);
          if (fcnt_q <= FW'(1)) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ret_q;               // ready wins over a coincident timeout
        end else if (tmo_q >= TMO_MAX) begin
          err_d   = 1'b1;
          state_d = ret_q;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // Reset holds the pipeline cleared regardless of anything else.
    if (!rst) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fcnt_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = err_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flushc_q, mwait_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      flushc_q <= '0;
      mwait_q  <= '0;
    end else begin
      if (!pc_en && stall_q != '1)              stall_q  <= stall_q + CNT_W'(1);
      if (ifid_flush && flushc_q != '1)         flushc_q <= flushc_q + CNT_W'(1);
      if (state_q == MEM_WAIT && mwait_q != '1) mwait_q  <= mwait_q + CNT_W'(1);
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flushc_q;
  assign memwait_cnt = mwait_q;
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: forwarding vectors from a table, control
// sequences checked cycle by cycle against expected values queued at drive time.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 16;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_waddr, mem_waddr, wb_waddr;
  logic          id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken;
  logic          mem_regwrite, wb_regwrite, dmem_req, dmem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, mem_err;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  pipeline_hazard_ctrl #(.REG_AW(AW), .FLUSH_DEPTH(2), .MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_waddr(ex_waddr), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, state[1:0]}
  localparam logic [7:0] C_RST  = 8'b0000_11_00;
  localparam logic [7:0] C_RUN  = 8'b1111_00_00;
  localparam logic [7:0] C_LU   = 8'b0011_01_00;
  localparam logic [7:0] C_LS   = 8'b1111_00_01;
  localparam logic [7:0] C_BR   = 8'b1111_11_00;
  localparam logic [7:0] C_BRF  = 8'b1111_10_10;
  localparam logic [7:0] C_BRMW = 8'b0000_00_10;
  localparam logic [7:0] C_MW0  = 8'b0000_00_00;
  localparam logic [7:0] C_MW   = 8'b0000_00_11;
  localparam logic [7:0] C_MWX  = 8'b1111_00_11;

  typedef struct {
    logic          mrw;
    logic [AW-1:0] mwa;
    logic          wrw;
    logic [AW-1:0] wwa;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } fwd_vec_t;

  fwd_vec_t   fv[9];
  logic [7:0] ctrl_q[$];
  logic [3:0] fwd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = '0; ex_rt = '0; ex_waddr = '0; ex_memread = 0; ex_branch_taken = 0;
    mem_waddr = '0; wb_waddr = '0; mem_regwrite = 0; wb_regwrite = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  // One cycle: queue the expected controls, compare at the falling edge,
  // then move to just after the next rising edge.
  task automatic cyc(input logic [7:0] exp, input string nm);
    logic [7:0] e;
    ctrl_q.push_back(exp);
    @(negedge clk);
    e = ctrl_q.pop_front();
    chk(nm, {24'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, state}, {24'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string nm, input int st, input int fl, input int mw);
    chk({nm, "_stall"},   32'(stall_cnt),   PERF ? st : 0);
    chk({nm, "_flush"},   32'(flush_cnt),   PERF ? fl : 0);
    chk({nm, "_memwait"}, 32'(memwait_cnt), PERF ? mw : 0);
  endtask

  initial begin
    fv[0] = '{1, 7, 1, 7, 7, 7, 2'b10, 2'b10};
    fv[1] = '{1, 0, 1, 0, 0, 0, 2'b00, 2'b00};
    fv[2] = '{0, 7, 1, 7, 7, 3, 2'b01, 2'b00};
    fv[3] = '{1, 3, 1, 7, 7, 3, 2'b01, 2'b10};
    fv[4] = '{1, 5, 0, 5, 5, 5, 2'b10, 2'b10};
    fv[5] = '{0, 5, 0, 5, 5, 5, 2'b00, 2'b00};
    fv[6] = '{1, 9, 1, 4, 4, 9, 2'b01, 2'b10};
    fv[7] = '{1, 31, 1, 31, 31, 0, 2'b10, 2'b00};
    fv[8] = '{1, 0, 1, 6, 0, 6, 2'b00, 2'b01};

    // Reset, with a live forwarding match that must be masked.
    rst = 0; idle();
    mem_regwrite = 1; mem_waddr = 7; ex_rs = 7;
    repeat (2) @(posedge clk); #1;
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    cyc(C_RST, "rst_ctrl");
    chk_cnt("rst", 0, 0, 0);
    rst = 1; idle();
    cyc(C_RUN, "rel_ctrl");

    // Forwarding table
    for (int i = 0; i < 9; i++) begin
      logic [3:0] e;
      mem_regwrite = fv[i].mrw; mem_waddr = fv[i].mwa;
      wb_regwrite  = fv[i].wrw; wb_waddr  = fv[i].wwa;
      ex_rs = fv[i].rs; ex_rt = fv[i].rt;
      fwd_q.push_back({fv[i].fa, fv[i].fb});
      @(negedge clk);
      e = fwd_q.pop_front();
      chk($sformatf("fwd_a[%0d]", i), 32'(fwd_a), 32'(e[3:2]));
      chk($sformatf("fwd_b[%0d]", i), 32'(fwd_b), 32'(e[1:0]));
      @(posedge clk); #1;
    end
    idle();

    // Load-use: non-hazards, then rs hazard with the condition held into LOAD_STALL
    ex_memread = 1; ex_waddr = 0; id_rs = 0; id_uses_rs = 1;
    cyc(C_RUN, "lu_r0");
    ex_waddr = 5; id_rs = 5; id_uses_rs = 0;
    cyc(C_RUN, "lu_nouse");
    id_uses_rs = 1;
    cyc(C_LU, "lu_stall");
    cyc(C_LS, "lu_suppress");
    idle();
    cyc(C_RUN, "lu_back");
    chk_cnt("lu", 1, 0, 0);
    ex_memread = 1; ex_waddr = 9; id_rt = 9; id_uses_rt = 1;
    cyc(C_LU, "lu_rt");
    idle();
    cyc(C_LS, "lu_rt_ls");

    // Branch and load-use together
    ex_branch_taken = 1; ex_memread = 1; ex_waddr = 5; id_rs = 5; id_uses_rs = 1;
    cyc(C_BR, "br_lu");
    idle();
    cyc(C_BRF, "br_flush");
    cyc(C_RUN, "br_back");
    chk_cnt("br", 2, 2, 0);

    // Memory wait, ready on the fourth cycle
    dmem_req = 1;
    cyc(C_MW0, "mw_enter");
    cyc(C_MW, "mw_1");
    cyc(C_MW, "mw_2");
    dmem_ready = 1;
    cyc(C_MWX, "mw_ready");
    idle();
    cyc(C_RUN, "mw_back");
    chk("mw_err", 32'(mem_err), 0);
    chk_cnt("mw", 5, 2, 3);

    // Memory wait interrupting BR_FLUSH resumes the flush afterwards
    ex_branch_taken = 1;
    cyc(C_BR, "bm_br");
    idle(); dmem_req = 1;
    cyc(C_BRMW, "bm_freeze");
    cyc(C_MW, "bm_wait");
    dmem_ready = 1;
    cyc(C_MWX, "bm_ready");
    idle();
    cyc(C_BRF, "bm_resume");
    cyc(C_RUN, "bm_back");
    chk_cnt("bm", 7, 4, 5);

    // Timeout: 16 MEM_WAIT cycles, then sticky error
    dmem_req = 1;
    cyc(C_MW0, "to_enter");
    for (int i = 0; i < 15; i++) cyc(C_MW, "to_wait");
    chk("to_err_pre", 32'(mem_err), 0);
    cyc(C_MWX, "to_expire");
    chk("to_err", 32'(mem_err), 1);
    cyc(C_MW0, "to_reenter");
    dmem_req = 0; dmem_ready = 1;
    cyc(C_MWX, "to_ready");
    idle();
    cyc(C_RUN, "to_back");
    chk("to_sticky", 32'(mem_err), 1);
    chk_cnt("to", 24, 4, 22);

    // Reset clears error and counters
    rst = 0;
    cyc(C_RST, "rst2");
    rst = 1;
    chk("rst2_err", 32'(mem_err), 0);
    chk_cnt("rst2", 0, 0, 0);

    // Ready arriving on the timeout cycle counts as ready
    dmem_req = 1;
    cyc(C_MW0, "rt_enter");
    for (int i = 0; i < 15; i++) cyc(C_MW, "rt_wait");
    dmem_ready = 1;
    cyc(C_MWX, "rt_both");
    idle();
    cyc(C_RUN, "rt_back");
    chk("rt_err", 32'(mem_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Generates per-stage enable, flush and bubble controls.
- Generates operand-forwarding selects for the EX stage.
- Sequences multi-cycle events (load-use stall, taken-branch flush, data-memory wait) with a small FSM.
- Sits beside the pipeline registers; all datapath stage registers take their enables from this block.

Parameters:
REG_AW, 5, register address width
FLUSH_DEPTH, 2, cycles ifid_flush stays asserted after a taken branch (min 1)
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error abort (min 2)
CNT_W, 16, performance counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
ex_rs, ex_rt  in  REG_AW  source registers of the instruction in EX
ex_waddr  in  REG_AW  destination register in EX
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX
mem_waddr, wb_waddr  in  REG_AW  destination registers in MEM / WB
mem_regwrite, wb_regwrite  in  1  MEM / WB instruction writes the register file
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes access this cycle
pc_en, ifid_en, idex_en, exmem_en  out  1  stage register load enables
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 from MEM, 01 from WB
state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 BR_FLUSH, 3 MEM_WAIT
mem_err  out  1  sticky data-memory timeout flag
stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters

Behaviour:
Reset (rst==0 sampled at posedge clk):
- state=RUN; internal counters=0; mem_err=0; perf counters=0.
- While rst is low, outputs are forced combinationally: all *_en=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=00.
- Reset wins over any other event in the same cycle.

Forwarding (combinational, all states):
- fwd_a=10 if mem_regwrite && mem_waddr!=0 && mem_waddr==ex_rs.
- Otherwise fwd_a=01 if wb_regwrite && wb_waddr!=0 && wb_waddr==ex_rs.
- Otherwise fwd_a=00.
- fwd_b is identical using ex_rt. MEM has priority over WB. Register 0 is never forwarded.

Control outputs (combinational from state and inputs); default all *_en=1, flush/bubble=0.

Priority in RUN: mem wait > branch > load-use.
- Mem wait: dmem_req && !dmem_ready.
  - All *_en=0; next state MEM_WAIT; timeout counter loads 1.
- Branch: ex_branch_taken.
  - ifid_flush=1, idex_bubble=1, pc_en=1 (target loads).
  - If FLUSH_DEPTH>1: next state BR_FLUSH with flush counter loaded to FLUSH_DEPTH-1.
- Load-use: ex_memread && ex_waddr!=0 && ((id_uses_rs && id_rs==ex_waddr) || (id_uses_rt && id_rt==ex_waddr)).
  - pc_en=0, ifid_en=0, idex_bubble=1; next state LOAD_STALL.

LOAD_STALL:
- Lasts exactly 1 cycle; outputs at default; load-use detection is suppressed; mem-wait check still applies (priority as in RUN).
- Next state RUN.

BR_FLUSH:
- ifid_flush=1; flush counter decrements each cycle; return to RUN when it reaches 0.
- A mem wait in this state goes to MEM_WAIT; the remaining flush count is held and resumed in BR_FLUSH after the wait.

MEM_WAIT:
- All *_en=0 until exit.
- dmem_ready=1: enables at default this cycle; next state = saved return state (RUN, or BR_FLUSH if interrupted).
- Timeout: counter reaches MEM_TIMEOUT with no ready → mem_err<=1 (sticky until reset), enables at default, exit as above.
- Ready and timeout in the same cycle: treated as ready, mem_err unchanged.
- Because the pipeline is frozen, pending load-use/branch conditions are re-evaluated naturally after exit.

Optional Feature:
PERF_CNT_EN
- Defined:
  - stall_cnt increments on each cycle with pc_en==0 and rst==1.
  - flush_cnt increments on each cycle with ifid_flush==1 and rst==1.
  - memwait_cnt increments on each cycle spent in MEM_WAIT.
  - All three saturate at 2^CNT_W-1.
- Undefined: the three ports are constant 0 and no counter flops exist.

Test Plan:
- Reset: hold rst=0 for 2 clocks → state=0, mem_err=0, pc_en=0, ifid_flush=1; release → pc_en=ifid_en=idex_en=exmem_en=1 next cycle.
- Load-use: ex_memread=1, ex_waddr=5, id_rs=5, id_uses_rs=1 → 1 cycle pc_en=0, ifid_en=0, idex_bubble=1; state=1 next cycle; then RUN; stall_cnt=1 (PERF_CNT_EN).
- Forwarding: mem_waddr=wb_waddr=ex_rs=7, both regwrite=1 → fwd_a=10; ex_rs=0 with mem_waddr=0 → fwd_a=00.
- Branch vs load-use same cycle, FLUSH_DEPTH=2: both conditions true → ifid_flush=1, idex_bubble=1, pc_en=1; state=2 for 1 cycle; flush_cnt=2.
- Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → all enables 0 for 3 cycles, state=3; enables=1 on the ready cycle; memwait_cnt=3; mem_err=0.
- Timeout, MEM_TIMEOUT=16: dmem_ready held 0 → mem_err=1 after 16 MEM_WAIT cycles, state returns to 0; mem_err stays 1 until rst=0.
